// File: rtl/sync_memory_pkg.sv
// Shared definitions for the synchronous word memory.
//   MEM_DATA_WIDTH / MEM_ADDR_WIDTH : default word and address widths
//   mem_state_e                     : controller states (clear sweep, idle)
package sync_memory_pkg;

   localparam int MEM_DATA_WIDTH = 8;
   localparam int MEM_ADDR_WIDTH = 3;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } mem_state_e;

endpackage

// File: rtl/sync_memory_if.sv
// Request/response bundle for sync_memory.
//   select, rw, address, data_in : requester -> memory
//   ready, data_out, valid       : memory -> requester
// master = requester side, slave = memory side.
interface sync_memory_if
   import sync_memory_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

   logic                  select;
   logic                  rw;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid;

   modport master (
      output select, rw, address, data_in,
      input  ready, data_out, valid
   );

   modport slave (
      input  select, rw, address, data_in,
      output ready, data_out, valid
   );

endinterface

// File: rtl/sync_memory_decoder.sv
// Binary-to-one-hot word enable decoder, purely combinational.
//   addr    : binary word address
//   word_en : one bit per word, exactly one set
module sync_memory_decoder
   import sync_memory_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0]    addr,
   output logic [2**ADDR_WIDTH-1:0] word_en
);

   always_comb begin
      word_en       = '0;
      word_en[addr] = 1'b1;
   end

endmodule

// File: rtl/sync_memory.sv
// Synchronous single-port word memory, DEPTH = 2**ADDR_WIDTH words.
// After every reset a clear sweep zeroes the array before requests are taken.
//   clk   : clock, all state updates on rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of sync_memory_if (select/rw/address/data_in in,
//           ready/data_out/valid out; read data one cycle after acceptance)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zeroing word clr_cnt each cycle, requests ignored, ready=0
// ST_IDLE  | ready=1, serving one request per cycle until next reset
module sync_memory
   import sync_memory_pkg::*;
#(
   parameter int DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   sync_memory_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH-1);

   mem_state_e            state, state_next;
   logic [ADDR_WIDTH:0]   clr_cnt, clr_cnt_next;
   logic                  ready_q, ready_next;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic                  wr_en;
   logic                  rd_accept;
   logic [ADDR_WIDTH-1:0] dec_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DEPTH-1:0]      dec_onehot;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= clr_cnt_next;
         ready_q <= ready_next;
         valid_q <= rd_accept;
         if (rd_accept) data_q <= mem[bus.address];
      end
   end

   // The decoder is shared: it points at clr_cnt during the sweep and at
   // the requested address afterwards.
   always_comb begin
      state_next   = state;
      clr_cnt_next = clr_cnt;
      ready_next   = ready_q;
      wr_en        = 1'b0;
      rd_accept    = 1'b0;
      dec_addr     = bus.address;
      wr_data      = bus.data_in;
      unique case (state)
         ST_CLEAR: begin
            wr_en        = 1'b1;
            dec_addr     = clr_cnt[ADDR_WIDTH-1:0];
            wr_data      = '0;
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
               state_next = ST_IDLE;
               ready_next = 1'b1;
            end
         end
         ST_IDLE: begin
            wr_en     = bus.select && ready_q && bus.rw;
            rd_accept = bus.select && ready_q && !bus.rw;
         end
         default: ;
      endcase
   end

   sync_memory_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
      .addr    (dec_addr),
      .word_en (dec_onehot)
   );

   // Array is left untouched while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (dec_onehot[i]) mem[i] <= wr_data;
         end
      end
   end

   assign bus.ready    = ready_q;
   assign bus.valid    = valid_q;
   assign bus.data_out = data_q;

endmodule
